// File: rtl/host_link_pkg.sv
// host_link_pkg
// Shared definitions for the host <-> FPGA multiply/accumulate UART link:
// opcode values (also used by the FPGA-side command decoder), frame lengths,
// response length, host_cmd state encoding and framing helpers.
package host_link_pkg;

  // Opcodes carried in the second frame byte
  localparam logic [2:0] OP_OUT_DATA1  = 3'd0;
  localparam logic [2:0] OP_OUT_DATA2  = 3'd1;
  localparam logic [2:0] OP_OUT_RES    = 3'd2;
  localparam logic [2:0] OP_OUT_RES_ADD = 3'd3;
  localparam logic [2:0] OP_LOAD_RES   = 3'd4;
  localparam logic [2:0] OP_MUL        = 3'd5;
  localparam logic [2:0] OP_MUL_ADD    = 3'd6;
  localparam logic [2:0] OP_NO_OP      = 3'd7;

  // Frame lengths in bytes: ADDR + opcode (+ 4 payload bytes)
  localparam int FRAME_LEN_DATA = 6;
  localparam int FRAME_LEN_CTRL = 2;

  // Response length of the result-read opcodes; fixed by the protocol
  localparam int RSP_BYTES = 16;

  // host_cmd state encoding
  localparam logic [2:0] ST_IDLE = 3'd0;
  localparam logic [2:0] ST_SEND = 3'd1;
  localparam logic [2:0] ST_GAP  = 3'd2;
  localparam logic [2:0] ST_RESP = 3'd3;
  localparam logic [2:0] ST_DONE = 3'd4;

  // Command as latched on accept
  typedef struct packed {
    logic [2:0]  op;
    logic [31:0] data;
  } cmd_t;

  function automatic logic op_has_data(input logic [2:0] op);
    return (op == OP_OUT_DATA1) || (op == OP_OUT_DATA2);
  endfunction

  function automatic logic op_has_rsp(input logic [2:0] op);
    return (op == OP_OUT_RES) || (op == OP_OUT_RES_ADD);
  endfunction

  // Index of the final byte of the frame for this opcode
  function automatic logic [2:0] frame_last_idx(input logic [2:0] op);
    return op_has_data(op) ? 3'(FRAME_LEN_DATA - 1) : 3'(FRAME_LEN_CTRL - 1);
  endfunction

  // Byte idx of the frame: ADDR, {5'b0, op}, data MSB first
  function automatic logic [7:0] frame_byte(input logic [7:0] addr,
                                            input cmd_t cmd,
                                            input logic [2:0] idx);
    logic [7:0] b;
    b = cmd.data[7:0];
    case (idx)
      3'd0:    b = addr;
      3'd1:    b = {5'b0, cmd.op};
      3'd2:    b = cmd.data[31:24];
      3'd3:    b = cmd.data[23:16];
      3'd4:    b = cmd.data[15:8];
      default: b = cmd.data[7:0];
    endcase
    return b;
  endfunction

endpackage

// File: rtl/host_rsp_timer.sv
// host_rsp_timer
// Response inactivity timer: a down-counter reloaded to TIMEOUT-1 by restart
// and decremented while enable is high. expired is high once the count has
// run down to zero, i.e. after TIMEOUT enabled cycles without a restart.
// Ports:
//   clk, nRst  clock, asynchronous active-low reset
//   restart    reload the counter (takes priority over enable)
//   enable     count down this cycle
//   expired    count is zero
module host_rsp_timer #(
  parameter int TIMEOUT = 50000
) (
  input  logic clk,
  input  logic nRst,
  input  logic restart,
  input  logic enable,
  output logic expired
);

  localparam int W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [W-1:0] LOAD = W'(TIMEOUT - 1);

  logic [W-1:0] count_reg;

  always_ff @(posedge clk or negedge nRst) begin
    if (!nRst) begin
      count_reg <= '0;
    end else if (restart) begin
      count_reg <= LOAD;
    end else if (enable && (count_reg != '0)) begin
      count_reg <= count_reg - W'(1);
    end
  end

  assign expired = (count_reg == '0);

endmodule

// File: rtl/host_cmd.sv
// host_cmd
// Host-side command initiator. Accepts a command from local logic, frames it
// as ADDR, {5'b0, op} and, for data opcodes, 4 payload bytes MSB first on
// the UART tx byte interface. Result-read opcodes then collect a 16-byte
// response from the UART rx byte interface, guarded by an inactivity timeout.
// Ports:
//   clk, nRst              clock, asynchronous active-low reset
//   cmd_valid/cmd_ready    command handshake (ready only in IDLE)
//   cmd_op, cmd_data       opcode and payload, latched on accept
//   tx_data, tx_send       byte + one-cycle strobe to the uart transmitter
//   tx_busy                uart transmitter busy
//   rx_data, rx_valid      received byte + one-cycle strobe
//   cmd_done               one-cycle completion pulse
//   rsp_timeout            with cmd_done: response incomplete
//   rsp_data               with cmd_done: response, first byte in [127:120]
module host_cmd #(
  parameter logic [7:0] ADDR      = 8'h00,
  parameter int         TIMEOUT   = 50000,
  parameter int         RSP_BYTES = 16
) (
  input  logic         clk,
  input  logic         nRst,
  input  logic         cmd_valid,
  output logic         cmd_ready,
  input  logic [2:0]   cmd_op,
  input  logic [31:0]  cmd_data,
  output logic [7:0]   tx_data,
  output logic         tx_send,
  input  logic         tx_busy,
  input  logic [7:0]   rx_data,
  input  logic         rx_valid,
  output logic         cmd_done,
  output logic         rsp_timeout,
  output logic [127:0] rsp_data
);

  import host_link_pkg::*;

  logic [2:0]   state_reg, state_next;
  cmd_t         cmd_reg;
  logic [2:0]   idx_reg;
  logic [3:0]   rsp_cnt_reg;
  logic [7:0]   tx_data_reg;
  logic         tx_send_reg;
  logic         cmd_done_reg;
  logic         rsp_timeout_reg;
  logic [127:0] rsp_data_reg;

  logic accept;
  logic frame_last;
  logic rsp_last;
  logic timer_restart;
  logic timer_expired;

  assign cmd_ready  = (state_reg == ST_IDLE);
  assign accept     = cmd_valid & cmd_ready;
  assign frame_last = (idx_reg == frame_last_idx(cmd_reg.op));
  assign rsp_last   = (rsp_cnt_reg == 4'(RSP_BYTES - 1));

  // The timer restarts as RESP is entered and on every received byte, so it
  // measures the gap before the first byte and between successive bytes.
  assign timer_restart = ((state_reg == ST_GAP) && frame_last && op_has_rsp(cmd_reg.op)) ||
                         ((state_reg == ST_RESP) && rx_valid);

  host_rsp_timer #(
    .TIMEOUT (TIMEOUT)
  ) u_timer (
    .clk     (clk),
    .nRst    (nRst),
    .restart (timer_restart),
    .enable  (state_reg == ST_RESP),
    .expired (timer_expired)
  );

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_IDLE: if (accept) state_next = ST_SEND;
      ST_SEND: if (!tx_busy) state_next = ST_GAP;
      ST_GAP: begin
        if (frame_last) begin
          state_next = op_has_rsp(cmd_reg.op) ? ST_RESP : ST_DONE;
        end else begin
          state_next = ST_SEND;
        end
      end
      ST_RESP: begin
        // A byte arriving in the expiry cycle wins over the timeout
        if (rx_valid) begin
          if (rsp_last) state_next = ST_DONE;
        end else if (timer_expired) begin
          state_next = ST_DONE;
        end
      end
      ST_DONE: state_next = ST_IDLE;
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge nRst) begin
    if (!nRst) begin
      state_reg       <= ST_IDLE;
      cmd_reg         <= '0;
      idx_reg         <= '0;
      rsp_cnt_reg     <= '0;
      tx_data_reg     <= '0;
      tx_send_reg     <= 1'b0;
      cmd_done_reg    <= 1'b0;
      rsp_timeout_reg <= 1'b0;
      rsp_data_reg    <= '0;
    end else begin
      state_reg    <= state_next;
      tx_send_reg  <= 1'b0;
      // DONE lasts exactly one cycle, so this yields a one-cycle pulse
      cmd_done_reg <= (state_next == ST_DONE);
      case (state_reg)
        ST_IDLE: begin
          if (accept) begin
            cmd_reg         <= '{op: cmd_op, data: cmd_data};
            idx_reg         <= '0;
            rsp_cnt_reg     <= '0;
            rsp_data_reg    <= '0;
            rsp_timeout_reg <= 1'b0;
          end
        end
        ST_SEND: begin
          if (!tx_busy) begin
            tx_send_reg <= 1'b1;
            tx_data_reg <= frame_byte(ADDR, cmd_reg, idx_reg);
          end
        end
        ST_GAP: begin
          if (!frame_last) idx_reg <= idx_reg + 3'd1;
        end
        ST_RESP: begin
          if (rx_valid) begin
            rsp_data_reg <= {rsp_data_reg[119:0], rx_data};
            rsp_cnt_reg  <= rsp_cnt_reg + 4'd1;
          end else if (timer_expired) begin
            rsp_timeout_reg <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign tx_data     = tx_data_reg;
  assign tx_send     = tx_send_reg;
  assign cmd_done    = cmd_done_reg;
  assign rsp_timeout = rsp_timeout_reg;
  assign rsp_data    = rsp_data_reg;

endmodule

// File: doc/host_cmd.md
# host_cmd

Host-side command initiator for the multiply/accumulate link. Takes a command from local logic and frames it as a UART byte stream: address, opcode, and optionally 4 data bytes. For result-read opcodes it then collects the 16-byte response from the UART receiver, with a timeout. It sits between host control logic and the uart tx/rx byte interfaces, opposite the FPGA-side command decoder.

## Interface
Parameters:
- ADDR, 8'h00, address byte sent first in every frame
- TIMEOUT, 50000, max clk cycles allowed between response bytes (and before the first one)
- RSP_BYTES, 16, response length in bytes; fixed by protocol, not to be overridden

Ports:
- clk  in  1  clock
- nRst  in  1  reset, asynchronous, active-low
- cmd_valid  in  1  command request
- cmd_ready  out  1  high only in IDLE; command accepted when cmd_valid & cmd_ready
- cmd_op  in  3  opcode (see Operation)
- cmd_data  in  32  payload for data opcodes
- tx_data  out  8  byte to transmit; stable while tx_send is high
- tx_send  out  1  one-cycle transmit strobe
- tx_busy  in  1  uart tx busy; rises the cycle after tx_send
- rx_data  in  8  received byte
- rx_valid  in  1  one-cycle strobe, rx_data valid
- cmd_done  out  1  one-cycle pulse, command complete
- rsp_timeout  out  1  valid with cmd_done; 1 = response incomplete
- rsp_data  out  128  response; valid with cmd_done for result opcodes

## Operation
- Opcodes:
  - 0 OUT_DATA1, 1 OUT_DATA2: data frame, 6 bytes.
  - 2 OUT_RES, 3 OUT_RES_ADD: 2-byte frame, then 16-byte response.
  - 4 LOAD_RES, 5 MUL, 6 MUL_ADD, 7 NO_OP: 2-byte frame, no response.
- Frame byte order: ADDR, {5'b0, cmd_op}, then cmd_data[31:24], [23:16], [15:8], [7:0].
- On accept, op and data are latched. Later changes on cmd_* are ignored until the next IDLE.
- States:
  - IDLE: cmd_ready=1; on accept, clear byte index, rsp_data and rsp_timeout → SEND.
  - SEND: wait for !tx_busy; drive tx_data = byte[idx], pulse tx_send → GAP.
  - GAP: one cycle so tx_busy can rise. If idx is the last frame byte → RESP (opcodes 2/3) or DONE (others); else idx+1 → SEND.
  - RESP: clear the timer on entry and on each rx_valid.
    - On rx_valid, shift the byte in: rsp_data <= {rsp_data[119:0], rx_data}. The first received byte ends in [127:120].
    - After the 16th byte → DONE, rsp_timeout=0.
    - When the timer reaches TIMEOUT-1 with no rx_valid → DONE, rsp_timeout=1; rsp_data holds the partial shift.
  - DONE: cmd_done=1 for one cycle → IDLE.
- rx_valid outside RESP is ignored. rx_valid in the same cycle the timer expires: the byte is taken and the timer restarts; no timeout.
- Byte counter 4 bits (0–15); timer width $clog2(TIMEOUT).

## Timing
- Reset values: state IDLE, cmd_ready 1, tx_send 0, tx_data 0, cmd_done 0, rsp_timeout 0, rsp_data 0.
- Reset mid-frame or mid-response: immediate abort, no cmd_done; tx_send drops asynchronously.
- All outputs are registered except cmd_ready, which decodes state.
- Accept at edge N; with tx_busy low, the first tx_send is high in cycle N+1.
- Per byte: minimum 2 cycles (SEND+GAP) plus the time tx_busy stays high.
- tx_send never asserts while tx_busy is high, and never on two consecutive cycles.
- No-response ops: cmd_done is the cycle after the final GAP.
- Response ops: cmd_done is the cycle after the 16th rx_valid, or after timeout expiry.
- cmd_done → cmd_ready high in the next cycle. Back-to-back commands have no other gap.

## Structure
- Shared package host_link_pkg holds:
  - opcode constants (shared with the FPGA-side decoder)
  - frame lengths 6/2
  - RSP_BYTES
  - state encoding
- One sub-module, host_rsp_timer: loadable down-counter with clear and expiry flag, parameter TIMEOUT.
- Shift register and framing logic stay in host_cmd.

## Test plan
- op=0, data=32'hDEADBEEF, ADDR=8'h5A, tx_busy model 10 cycles → tx bytes 5A,00,DE,AD,BE,EF; one cmd_done; rsp_timeout=0.
- op=5, tx_busy held high 20 cycles before the first byte → bytes 5A,05 only; no tx_send while busy; cmd_done after the second GAP.
- op=2, responder returns bytes 00..0F → rsp_data=128'h000102030405060708090A0B0C0D0E0F; cmd_done the cycle after the last rx_valid; rsp_timeout=0.
- op=3, TIMEOUT=100, only 5 bytes returned (11..15) → cmd_done 100 cycles after the 5th byte; rsp_timeout=1; rsp_data[39:0]=40'h1112131415.
- rx_valid strobes while in IDLE and during SEND → ignored; subsequent op=2 response is uncorrupted.
- nRst pulsed after the 3rd byte of op=1 → no cmd_done; next command framed correctly from ADDR.
